led_event_stretcher: RTL

- Multi-channel successor to the single key_valid LED hold logic in the top level.
- Each channel turns short event pulses (key_valid, per-key key_down bits, score changes) into LED pulses long enough to see.
- Runtime mode selects per channel: retrigger (extend while events keep arriving) or blink (each event is a separate, gap-separated blink, one event queued).
- Sits between keyboardDecoder/game_logic outputs and board LEDs, in the clk_25MHz domain.

---
 rtl/led_event_stretcher.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/led_event_stretcher.sv
// -----------------------------------------------------------------------------
// led_event_stretcher
//
// Purpose:
//   Stretches short event pulses into LED pulses that are long enough to see.
//   There are NUM_CH independent channels. The mode input selects how each
//   channel behaves, and it is sampled every cycle:
//     mode=0 (retrigger): each event reloads the hold time, so the LED stays
//                         lit while events keep arriving.
//     mode=1 (blink)    : each event becomes its own blink. After a blink the
//                         LED is forced off for GAP_CYCLES. One further event
//                         can be queued; any event beyond that is dropped.
//
// Ports:
//   clk        : clock, the same domain as the event sources
//   rst        : synchronous active-high reset
//   event_in   : [NUM_CH] per-channel event request
//   mode       : [NUM_CH] per-channel mode, 0 = retrigger, 1 = blink
//   led        : [NUM_CH] stretched LED drive, high exactly while in ON
//   busy       : OR over all channels of (state != IDLE)
//   drop_pulse : [NUM_CH] one-cycle pulse when an event is discarded
// -----------------------------------------------------------------------------
module led_event_stretcher #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 20,
    parameter int HOLD_CYCLES = 1048575,
    parameter int GAP_CYCLES  = 262144,
    parameter int EDGE_DET    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] event_in,
    input  logic [NUM_CH-1:0] mode,
    output logic [NUM_CH-1:0] led,
    output logic              busy,
    output logic [NUM_CH-1:0] drop_pulse
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Counters hold "cycles remaining minus one", so a count of zero marks the
    // last cycle of the current phase.
    localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_RELOAD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
    localparam logic             HAS_GAP     = (GAP_CYCLES > 0);

    logic [NUM_CH-1:0] prev_q;
    logic [NUM_CH-1:0] prev_d;
    logic [NUM_CH-1:0] ev;
    logic [NUM_CH-1:0] active;

    // prev_q is cleared by reset. An input held high through reset therefore
    // shows up as a rising edge on the first cycle after reset.
    always_comb begin
        prev_d = event_in;
        if (EDGE_DET != 0) begin
            ev = event_in & ~prev_q;
        end else begin
            ev = event_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            state_t           state_q, state_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             pend_q, pend_d;
            logic             drop_q, drop_d;
            logic             pend_eff;
            logic             cnt_zero;
            logic             q_set;
            logic             q_drop;

            always_comb begin
                // Setting mode to 0 discards any queued blink immediately.
                pend_eff = pend_q & mode[gi];
                cnt_zero = (cnt_q == '0);
                // Only blink mode can queue an event. A second event that
                // arrives while one is already queued is dropped.
                q_set    = ev[gi] & mode[gi] & ~pend_eff;
                q_drop   = ev[gi] & mode[gi] & pend_eff;

                state_d  = state_q;
                cnt_d    = cnt_q;
                pend_d   = pend_eff;
                drop_d   = 1'b0;

                case (state_q)
                    ST_IDLE: begin
                        pend_d = 1'b0;
                        if (ev[gi]) begin
                            state_d = ST_ON;
                            cnt_d   = HOLD_RELOAD;
                        end
                    end

                    ST_ON: begin
                        if (!mode[gi]) begin
                            pend_d = 1'b0;
                            if (ev[gi]) begin
                                cnt_d = HOLD_RELOAD;
                            end else if (cnt_zero) begin
                                state_d = ST_IDLE;
                            end else begin
                                cnt_d = cnt_q - 1'b1;
                            end
                        end else if (cnt_zero && !HAS_GAP) begin
                            // With no gap, a queued event starts the next blink
                            // straight away. A new event on this same cycle
                            // takes the slot that was just freed.
                            if (pend_eff) begin
                                cnt_d  = HOLD_RELOAD;
                                pend_d = ev[gi];
                            end else if (ev[gi]) begin
                                cnt_d  = HOLD_RELOAD;
                                pend_d = 1'b0;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            if (cnt_zero) begin
                                state_d = ST_GAP;
                                cnt_d   = GAP_RELOAD;
                            end else begin
                                cnt_d = cnt_q - 1'b1;
                            end
                            if (q_set) begin
                                pend_d = 1'b1;
                            end
                            if (q_drop) begin
                                drop_d = 1'b1;
                            end
                        end
                    end

                    ST_GAP: begin
                        if (cnt_zero) begin
                            if (pend_eff) begin
                                state_d = ST_ON;
                                cnt_d   = HOLD_RELOAD;
                                pend_d  = ev[gi];
                            end else if (ev[gi]) begin
                                // Nothing is queued, so this event is handled
                                // like an event arriving in IDLE.
                                state_d = ST_ON;
                                cnt_d   = HOLD_RELOAD;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                            if (q_set) begin
                                pend_d = 1'b1;
                            end
                            if (q_drop) begin
                                drop_d = 1'b1;
                            end
                        end
                    end

                    default: begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        pend_d  = 1'b0;
                    end
                endcase
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    pend_q  <= 1'b0;
                    drop_q  <= 1'b0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    pend_q  <= pend_d;
                    drop_q  <= drop_d;
                end
            end

            assign led[gi]        = (state_q == ST_ON);
            assign active[gi]     = (state_q != ST_IDLE);
            assign drop_pulse[gi] = drop_q;
        end
    endgenerate

    assign busy = |active;

endmodule
